up_dn_counter_driver: RTL and testbench
=======================================

Name: up_dn_counter_driver

Overview:
Command-side controller for the 5-bit up/down counter. It accepts a target value over a valid/ready request interface and drives the counter's Load/Up/Down/IN inputs to reach that target. It observes the counter's Counter, High and Low outputs and reports completion or a stall. Two modes: ramp (single steps, rate-limited) or jump (one load).

Parameters:
WIDTH, 5, counter width; matches counter IN/Counter width
STEP_DIV, 4, hold cycles after each Load/Up/Down pulse before re-checking; legal range >=1

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
Req_Valid  in  1  request present
Req_Ready  out  1  controller idle, can accept a request
Req_Mode  in  1  0 = ramp, 1 = jump (load)
Req_Target  in  WIDTH  requested counter value
Cnt_Value  in  WIDTH  counter's Counter output
Cnt_High  in  1  counter's High flag (monitor only)
Cnt_Low  in  1  counter's Low flag (monitor only)
Load  out  1  to counter Load
Up  out  1  to counter Up
Down  out  1  to counter Down
IN_Data  out  WIDTH  to counter IN; always the latched target
Busy  out  1  request in progress
Done  out  1  one-cycle pulse: target reached
Err  out  1  one-cycle pulse: counter failed to move or mismatched

Behaviour:
- States: IDLE, LOAD, STEP, HOLD, CHECK.
- Load, Up, Down, Req_Ready and Busy are decoded from registered state only, with no input-to-output combinational path.
- At most one of Load, Up or Down is high in any cycle.
- Reset state: IDLE.
  - Outputs: Req_Ready=1, Busy=0, Load=Up=Down=0, Done=Err=0, IN_Data=0.
  - Internal: target=0, hold timer=0, stepped flag=0.
- Reset mid-operation: return to IDLE at once. Up, Down and Load drop asynchronously, so the counter sees no further command.
- IDLE: Req_Ready=1. When Req_Valid=1, latch target and mode; IN_Data takes the target on the same edge. Next state is LOAD (jump) or CHECK (ramp); stepped is cleared.
- LOAD: Load=1 for exactly one cycle, then HOLD. Set stepped.
- STEP: Up=1 if the latched direction is up, else Down=1, for exactly one cycle, then HOLD. Set stepped and record prev=Cnt_Value.
- HOLD: lasts STEP_DIV cycles, then CHECK.
- CHECK, decisions in priority order:
  1. Cnt_Value==target: go to IDLE; Done=1 in the first IDLE cycle.
  2. Jump mode (value mismatches after load): go to IDLE; Err=1.
  3. Ramp mode, stepped=1 and Cnt_Value==prev (stall, e.g. saturated or blocked counter): go to IDLE; Err=1.
  4. Otherwise: direction = up if Cnt_Value<target (unsigned compare), else down; go to STEP.
- Done and Err are mutually exclusive and last one cycle each. A new request may be accepted in that same IDLE cycle.
- Latency, with cycle 0 = the accept cycle:
  - Ramp over distance d: Done in cycle 2 + d*(STEP_DIV+2).
  - Jump: Done in cycle 3 + STEP_DIV.
  - d=0 (ramp): Done in cycle 2 with no pulses.
- Target is always within 0..2^WIDTH-1, so no wrap-around is ever commanded.
- Cnt_High and Cnt_Low are not used for decisions. Stall detection alone covers saturation.

Decomposition:
- Shared package up_dn_pkg: state enum, MODE_RAMP/MODE_JUMP constants, default WIDTH.
- One sub-module, hold_timer:
  - Down-counter with a $clog2(STEP_DIV+1)-bit count.
  - start input loads STEP_DIV-1; expired output flags zero.
  - Same asynchronous active-low reset.

Test Plan:
1. Reset: assert RST=0 mid-ramp while Up=1 -> Up drops immediately, Req_Ready=1, Busy=0, IN_Data=0; the counter model does not step.
2. Ramp up, STEP_DIV=4, counter at 3, target 7 -> 4 single-cycle Up pulses spaced 6 cycles apart, Cnt_Value=7, Done in cycle 26, Err never.
3. Ramp down, counter at 20, target 0 -> 20 Down pulses, Cnt_Low=1 at end, Done in cycle 122, no Up pulse seen.
4. Jump, counter at 5, target 31 -> Load=1 for one cycle with IN_Data=31, Cnt_High=1, Done in cycle 7.
5. Zero distance, ramp, counter at 12, target 12 -> no Load/Up/Down, Done in cycle 2; a back-to-back request in the Done cycle is accepted.
6. Stall: counter model ignores Up, at 9, target 15 -> one Up pulse, then Err=1 at the next CHECK exit, Done=0, Busy=0.

Source files
------------

// File: rtl/up_dn_pkg.sv
// Shared types and constants for the up/down counter command driver.
// The state enum is shared so that debug views and the top agree on encoding.
package up_dn_pkg;

    localparam int DEF_WIDTH    = 5;
    localparam int DEF_STEP_DIV = 4;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_JUMP = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_HOLD  = 3'd3,
        S_CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/up_dn_counter_driver_hold_timer.sv
// Settling timer: start loads STEP_DIV-1, then counts down to zero and parks there.
// expired_o is high whenever the count is zero.
module hold_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic expired_o
);

    localparam int CW = $clog2(STEP_DIV + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(STEP_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/up_dn_counter_driver.sv
// Command-side controller that walks (ramp) or loads (jump) an external
// up/down counter to a requested target and reports Done or a stall via Err.
//
// state   | meaning
// IDLE    | ready for a request; Done/Err pulse here
// LOAD    | one-cycle Load pulse with IN_Data = target
// STEP    | one-cycle Up or Down pulse, snapshot of counter value
// HOLD    | wait STEP_DIV cycles for the counter to settle
// CHECK   | compare counter to target, decide next move
module up_dn_counter_driver
    import up_dn_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Req_Valid,
    output logic             Req_Ready,
    input  logic             Req_Mode,
    input  logic [WIDTH-1:0] Req_Target,
    input  logic [WIDTH-1:0] Cnt_Value,
    input  logic             Cnt_High,
    input  logic             Cnt_Low,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic [WIDTH-1:0] IN_Data,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             mode_q, mode_d;
    logic             dir_up_q, dir_up_d;
    logic             stepped_q, stepped_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timer_start;
    logic             timer_expired;

    // High/Low are observed only; saturation shows up as a stall instead.
    logic unused_mon;
    assign unused_mon = Cnt_High ^ Cnt_Low;

    hold_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_hold_timer (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .start_i   (timer_start),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        prev_d      = prev_q;
        mode_d      = mode_q;
        dir_up_d    = dir_up_q;
        stepped_d   = stepped_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        timer_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req_Valid) begin
                    target_d  = Req_Target;
                    mode_d    = Req_Mode;
                    stepped_d = 1'b0;
                    state_d   = (Req_Mode == MODE_JUMP) ? S_LOAD : S_CHECK;
                end
            end
            S_LOAD: begin
                stepped_d   = 1'b1;
                timer_start = 1'b1;
                state_d     = S_HOLD;
            end
            S_STEP: begin
                stepped_d   = 1'b1;
                prev_d      = Cnt_Value;
                timer_start = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (timer_expired) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (Cnt_Value == target_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (mode_q == MODE_JUMP) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (stepped_q && (Cnt_Value == prev_q)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    dir_up_d = (Cnt_Value < target_q);
                    state_d  = S_STEP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            prev_q    <= '0;
            mode_q    <= MODE_RAMP;
            dir_up_q  <= 1'b0;
            stepped_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            prev_q    <= prev_d;
            mode_q    <= mode_d;
            dir_up_q  <= dir_up_d;
            stepped_q <= stepped_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Command outputs come straight from state so reset removes them at once.
    assign Req_Ready = (state_q == S_IDLE);
    assign Busy      = (state_q != S_IDLE);
    assign Load      = (state_q == S_LOAD);
    assign Up        = (state_q == S_STEP) && dir_up_q;
    assign Down      = (state_q == S_STEP) && !dir_up_q;
    assign IN_Data   = target_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_up_dn_counter_driver.sv
// Bench for up_dn_counter_driver: a 5-bit counter model plus an event-schedule
// model derived from the request latency rules, checked every cycle.
module tb_up_dn_counter_driver;

    localparam int W  = 5;
    localparam int SD = 4;
    localparam int MAXC = 256;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Req_Valid = 1'b0;
    logic         Req_Ready;
    logic         Req_Mode = 1'b0;
    logic [W-1:0] Req_Target = '0;
    logic [W-1:0] Cnt_Value;
    logic         Cnt_High, Cnt_Low;
    logic         Load, Up, Down, Busy, Done, Err;
    logic [W-1:0] IN_Data;

    always #5 CLK = ~CLK;

    up_dn_counter_driver #(.WIDTH(W), .STEP_DIV(SD)) dut (
        .CLK(CLK), .RST(RST),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req_Mode(Req_Mode), .Req_Target(Req_Target),
        .Cnt_Value(Cnt_Value), .Cnt_High(Cnt_High), .Cnt_Low(Cnt_Low),
        .Load(Load), .Up(Up), .Down(Down), .IN_Data(IN_Data),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    // Saturating counter model; blk_up makes it ignore Up (stall case).
    logic [W-1:0] cnt = '0;
    logic         pre_en = 1'b0;
    logic [W-1:0] pre_val = '0;
    logic         blk_up = 1'b0;

    always @(posedge CLK) begin
        if (pre_en)                             cnt <= pre_val;
        else if (Load)                          cnt <= IN_Data;
        else if (Up && !blk_up && cnt != 5'd31) cnt <= cnt + 5'd1;
        else if (Down && cnt != 5'd0)           cnt <= cnt - 5'd1;
    end
    assign Cnt_Value = cnt;
    assign Cnt_High  = (cnt == 5'd31);
    assign Cnt_Low   = (cnt == 5'd0);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected schedule for one request, cycle 0 = accept cycle.
    bit   exp_ld [MAXC];
    bit   exp_up [MAXC];
    bit   exp_dn [MAXC];
    int   exp_last = 0;
    bit   exp_err = 1'b0;
    logic [W-1:0] exp_tgt = '0;
    logic [W-1:0] prev_tgt = '0;

    task automatic plan(input bit mode, input int start, input int tgt, input bit blk);
        int d;
        for (int i = 0; i < MAXC; i++) begin
            exp_ld[i] = 0; exp_up[i] = 0; exp_dn[i] = 0;
        end
        exp_tgt = W'(tgt);
        exp_err = 0;
        if (mode) begin
            exp_ld[1] = 1;
            exp_last  = 3 + SD;
        end else if (blk && tgt > start) begin
            exp_up[2] = 1;
            exp_last  = 2 + (SD + 2);
            exp_err   = 1;
        end else begin
            d = (tgt > start) ? tgt - start : start - tgt;
            for (int k = 0; k < d; k++) begin
                if (tgt > start) exp_up[2 + k*(SD+2)] = 1;
                else             exp_dn[2 + k*(SD+2)] = 1;
            end
            exp_last = 2 + d*(SD+2);
        end
    endtask

    // Per-cycle compare against the schedule, plus event bookkeeping.
    bit chk_on = 0;
    int cyc = 0;
    int done_cyc = -1;
    int err_cyc = -1;

    always @(negedge CLK) begin
        if (chk_on) begin
            automatic bit at_idle = (cyc == 0) || (cyc == exp_last);
            check($sformatf("ready@%0d", cyc), Req_Ready, at_idle);
            check($sformatf("busy@%0d", cyc),  Busy, !at_idle);
            check($sformatf("load@%0d", cyc),  Load, exp_ld[cyc]);
            check($sformatf("up@%0d", cyc),    Up,   exp_up[cyc]);
            check($sformatf("down@%0d", cyc),  Down, exp_dn[cyc]);
            check($sformatf("done@%0d", cyc),  Done, (cyc == exp_last) && !exp_err);
            check($sformatf("err@%0d", cyc),   Err,  (cyc == exp_last) && exp_err);
            check($sformatf("in_data@%0d", cyc), IN_Data, (cyc == 0) ? prev_tgt : exp_tgt);
            if (Done && done_cyc < 0) done_cyc = cyc;
            if (Err && err_cyc < 0)   err_cyc = cyc;
            cyc = cyc + 1;
        end else begin
            cyc = 0;
        end
    end

    int n_up = 0, n_dn = 0, n_ld = 0;
    always @(negedge CLK) begin
        if (Up)   n_up++;
        if (Down) n_dn++;
        if (Load) n_ld++;
    end

    task automatic preset(input int v);
        @(posedge CLK); #1;
        pre_en = 1; pre_val = W'(v);
        @(posedge CLK); #1;
        pre_en = 0;
    endtask

    task automatic run_modeled(input bit mode, input int start, input int tgt, input bit blk);
        preset(start);
        plan(mode, start, tgt, blk);
        done_cyc = -1;
        err_cyc  = -1;
        @(posedge CLK); #1;
        blk_up = blk; Req_Valid = 1; Req_Mode = mode; Req_Target = W'(tgt);
        chk_on = 1;
        @(posedge CLK); #1;
        Req_Valid = 0;
        repeat (exp_last - 1) @(posedge CLK);
        @(negedge CLK); #1;
        chk_on = 0;
        prev_tgt = W'(tgt);
        blk_up = 0;
    endtask

    int u0, d0, l0;
    bit seen;
    logic [W-1:0] cnt_at_rst;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", Req_Ready, 1);
        check("rst_busy", Busy, 0);
        check("rst_cmd", {Load, Up, Down}, 0);
        check("rst_done_err", {Done, Err}, 0);
        check("rst_in_data", IN_Data, 0);
        @(negedge CLK); RST = 1;

        // Reset while Up is asserted: Up must vanish before the counter samples it.
        preset(3);
        @(posedge CLK); #1;
        Req_Valid = 1; Req_Mode = 0; Req_Target = 5'd7;
        @(posedge CLK); #1;
        Req_Valid = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge CLK); #1;
            if (Up) seen = 1;
        end
        check("midramp_up_seen", seen, 1);
        cnt_at_rst = cnt;
        RST = 0;
        #1;
        check("midramp_up_drop", Up, 0);
        check("midramp_ready", Req_Ready, 1);
        check("midramp_busy", Busy, 0);
        check("midramp_in_data", IN_Data, 0);
        repeat (2) @(posedge CLK);
        #1;
        check("midramp_cnt_frozen", cnt, cnt_at_rst);
        check("midramp_cnt_is_3", cnt, 3);
        @(negedge CLK); RST = 1;
        prev_tgt = '0;

        // Ramp up 3 -> 7.
        u0 = n_up; d0 = n_dn;
        run_modeled(0, 3, 7, 0);
        check("ramp_up_done_cyc", done_cyc, 26);
        check("ramp_up_err_cyc", err_cyc, -1);
        check("ramp_up_pulses", n_up - u0, 4);
        check("ramp_up_cnt", cnt, 7);

        // Ramp down 20 -> 0.
        u0 = n_up; d0 = n_dn;
        run_modeled(0, 20, 0, 0);
        check("ramp_dn_done_cyc", done_cyc, 122);
        check("ramp_dn_pulses", n_dn - d0, 20);
        check("ramp_dn_no_up", n_up - u0, 0);
        check("ramp_dn_low", Cnt_Low, 1);

        // Jump 5 -> 31.
        l0 = n_ld;
        run_modeled(1, 5, 31, 0);
        check("jump_done_cyc", done_cyc, 7);
        check("jump_loads", n_ld - l0, 1);
        check("jump_high", Cnt_High, 1);

        // Zero distance, with a back-to-back request in the Done cycle.
        preset(12);
        u0 = n_up; d0 = n_dn; l0 = n_ld;
        @(posedge CLK); #1;
        Req_Valid = 1; Req_Mode = 0; Req_Target = 5'd12;
        @(negedge CLK);
        check("zero_c0_ready", Req_Ready, 1);
        @(negedge CLK);
        check("zero_c1_busy", Busy, 1);
        @(negedge CLK);
        check("zero_c2_done", Done, 1);
        check("zero_c2_ready", Req_Ready, 1);
        @(posedge CLK); #1;
        Req_Valid = 0;
        check("zero_b2b_busy", Busy, 1);
        @(negedge CLK);
        @(negedge CLK);
        check("zero_b2b_done", Done, 1);
        check("zero_b2b_err", Err, 0);
        check("zero_no_pulses", (n_up - u0) + (n_dn - d0) + (n_ld - l0), 0);
        prev_tgt = 5'd12;

        // Stall: counter ignores Up.
        u0 = n_up;
        run_modeled(0, 9, 15, 1);
        check("stall_err_cyc", err_cyc, 8);
        check("stall_done_cyc", done_cyc, -1);
        check("stall_up_pulses", n_up - u0, 1);
        check("stall_busy_after", Busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
